// File: rtl/scmp_bus_responder_if.sv
// SC/MP external core bus as seen by a target: address/data/strobes in, read data and wait request out.
// No storage of its own; the responder registers every output it drives.
// The core side honours hold_n; the responder never stalls the strobe inputs.
interface scmp_bus_responder_if;
    logic [11:0] addr;
    logic [7:0]  d_cpu;
    logic        ads_n;
    logic        rd_n;
    logic        wr_n;
    logic [7:0]  d_rsp;
    logic        drive_en;
    logic        hold_n;

    modport master (
        output addr, d_cpu, ads_n, rd_n, wr_n,
        input  d_rsp, drive_en, hold_n
    );

    modport slave (
        input  addr, d_cpu, ads_n, rd_n, wr_n,
        output d_rsp, drive_en, hold_n
    );
endinterface

// File: rtl/scmp_bus_responder.sv
// SC/MP bus target: decodes a 2^WIN_LOG2 window and serves strobes from a synchronous memory port.
// Latency: read data 2+WAIT_CYCLES cycles after the rd sample, write pulse 1+WAIT_CYCLES after the wr sample.
// Backpressure: hold_n low while an access is in flight. SCMP_BUS_RSP_ROM_EN makes the window read-only.
module scmp_bus_responder #(
    parameter logic [11:0] BASE_ADDR   = 12'h000,
    parameter int          WIN_LOG2    = 10,
    parameter int          WAIT_CYCLES = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    scmp_bus_responder_if.slave bus,
    output logic [WIN_LOG2-1:0] mem_addr,
    output logic [7:0]          mem_wdata,
    output logic                mem_we,
    output logic                mem_re,
    input  logic [7:0]          mem_rdata,
    output logic                err
);

    typedef enum logic [2:0] {IDLE, ADDR, WAIT, MEMRD, DONE} state_e;

    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);
`ifdef SCMP_BUS_RSP_ROM_EN
    localparam logic WR_EN = 1'b0;
`else
    localparam logic WR_EN = 1'b1;
`endif

    state_e              state_q, state_d;
    logic                hit_q, hit_d;
    logic                rd_op_q, rd_op_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [WIN_LOG2-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]          mem_wdata_q, mem_wdata_d;
    logic                mem_we_q, mem_we_d;
    logic                mem_re_q, mem_re_d;
    logic [7:0]          d_rsp_q, d_rsp_d;
    logic                drive_en_q, drive_en_d;
    logic                hold_n_q, hold_n_d;
    logic                err_q, err_d;
    logic                addr_hit;

    assign addr_hit = ((bus.addr ^ BASE_ADDR) >> WIN_LOG2) == 12'h000;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            hit_q       <= 1'b0;
            rd_op_q     <= 1'b0;
            cnt_q       <= 4'd0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 8'h00;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            d_rsp_q     <= 8'h00;
            drive_en_q  <= 1'b0;
            hold_n_q    <= 1'b1;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            hit_q       <= hit_d;
            rd_op_q     <= rd_op_d;
            cnt_q       <= cnt_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            mem_re_q    <= mem_re_d;
            d_rsp_q     <= d_rsp_d;
            drive_en_q  <= drive_en_d;
            hold_n_q    <= hold_n_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        hit_d       = hit_q;
        rd_op_d     = rd_op_q;
        cnt_d       = cnt_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        mem_re_d    = 1'b0;
        d_rsp_d     = d_rsp_q;
        drive_en_d  = drive_en_q;
        hold_n_d    = hold_n_q;
        err_d       = err_q;

        if (!bus.ads_n) begin
            // An address strobe in any state abandons whatever cycle was in flight.
            hit_d      = addr_hit;
            mem_addr_d = bus.addr[WIN_LOG2-1:0];
            drive_en_d = 1'b0;
            d_rsp_d    = 8'h00;
            hold_n_d   = 1'b1;
            state_d    = ADDR;
        end else begin
            case (state_q)
                IDLE: state_d = IDLE;
                ADDR: begin
                    if (!bus.rd_n && !bus.wr_n) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else if (!bus.rd_n || !bus.wr_n) begin
                        state_d = DONE;
                        if (hit_q) begin
                            rd_op_d  = !bus.rd_n;
                            hold_n_d = 1'b0;
                            cnt_d    = WAIT_LD;
                            if (bus.rd_n) begin
                                mem_wdata_d = bus.d_cpu;
                                if (!WR_EN) err_d = 1'b1;
                            end
                            if (WAIT_CYCLES != 0) begin
                                state_d = WAIT;
                            end else if (!bus.rd_n) begin
                                mem_re_d = 1'b1;
                                state_d  = MEMRD;
                            end else begin
                                mem_we_d = WR_EN;
                            end
                        end
                    end
                end
                WAIT: begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        if (rd_op_q) begin
                            mem_re_d = 1'b1;
                            state_d  = MEMRD;
                        end else begin
                            mem_we_d = WR_EN;
                            state_d  = DONE;
                        end
                    end
                end
                MEMRD: begin
                    // First MEMRD cycle carries the read pulse; data arrives in the next one.
                    if (!mem_re_q) begin
                        d_rsp_d    = mem_rdata;
                        drive_en_d = 1'b1;
                        hold_n_d   = 1'b1;
                        state_d    = DONE;
                    end
                end
                DONE: begin
                    hold_n_d = 1'b1;
                    if (bus.rd_n && bus.wr_n) begin
                        drive_en_d = 1'b0;
                        d_rsp_d    = 8'h00;
                        state_d    = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign mem_we       = mem_we_q;
    assign mem_re       = mem_re_q;
    assign err          = err_q;
    assign bus.d_rsp    = d_rsp_q;
    assign bus.drive_en = drive_en_q;
    assign bus.hold_n   = hold_n_q;

endmodule

// File: doc/scmp_bus_responder.md
# scmp_bus_responder

Target-side bus interface for the SC/MP core's external bus. It decodes the address strobe, qualifies the address against a decode window and answers read/write strobes from a synchronous memory port. It inserts wait states through `hold_n` and drives read data back to the core's `D_i`. Several instances, each with its own window, may share one core bus; their `drive_en` outputs combine into the core's data-in mux.

## Interface
Parameters:
- `BASE_ADDR`, 12'h000: window base; must be aligned to 2^`WIN_LOG2`.
- `WIN_LOG2`, 10: window size is 2^`WIN_LOG2` bytes; legal range 1..12.
- `WAIT_CYCLES`, 0: extra wait cycles per access; legal range 0..15.

Ports:
- `clk` in 1: clock, shared with the core.
- `rst_n` in 1: reset, asynchronous, active-low.
- `addr` in 12: core address bus.
- `d_cpu` in 8: core write data (core `D_o`).
- `ads_n` in 1: address strobe, active-low.
- `rd_n` in 1: read strobe, active-low.
- `wr_n` in 1: write strobe, active-low.
- `d_rsp` out 8: read data to the core; 8'h00 whenever `drive_en` is 0.
- `drive_en` out 1: this instance is driving `d_rsp`.
- `hold_n` out 1: wait request, active-low.
- `mem_addr` out `WIN_LOG2`: offset within the window.
- `mem_wdata` out 8: write data.
- `mem_we` out 1: one-cycle write pulse.
- `mem_re` out 1: one-cycle read pulse.
- `mem_rdata` in 8: read data, valid in the cycle after `mem_re`.
- `err` out 1: sticky protocol/protection error; cleared only by reset.

## Operation
- All bus inputs are sampled at posedge `clk`. Registered outputs change only on posedge.
- Reset values:
  - `d_rsp` = 8'h00, `drive_en` = 0, `hold_n` = 1
  - `mem_addr` = 0, `mem_wdata` = 0
  - `mem_we` = 0, `mem_re` = 0, `err` = 0
  - State = IDLE.
- States: IDLE, ADDR, WAIT, MEMRD, DONE.
- IDLE:
  - `ads_n` = 0 latches `addr`.
  - `hit_q` is set when `(addr ^ BASE_ADDR) >> WIN_LOG2 == 0`.
  - `mem_addr` is set to `addr[WIN_LOG2-1:0]`.
  - Next state: ADDR.
- ADDR, `rd_n` = 0 with hit:
  - Load the wait counter with `WAIT_CYCLES` and drive `hold_n` = 0.
  - Go to WAIT, or go directly to MEMRD with `mem_re` = 1 when `WAIT_CYCLES` = 0.
- ADDR, `wr_n` = 0 with hit:
  - Latch `d_cpu` into `mem_wdata` and drive `hold_n` = 0.
  - Go to WAIT, or pulse `mem_we` and go to DONE when `WAIT_CYCLES` = 0.
- WAIT: the counter decrements once per cycle. On reaching 0:
  - for a read, assert `mem_re` for one cycle and go to MEMRD;
  - for a write, assert `mem_we` for one cycle and go to DONE.
- MEMRD: register `mem_rdata` into `d_rsp`, set `drive_en` = 1 and `hold_n` = 1, then go to DONE.
- DONE:
  - Remain until `rd_n` and `wr_n` are both sampled high.
  - On that edge, `drive_en` = 0 and `d_rsp` = 0, and the state returns to IDLE.
- Miss (`hit_q` = 0):
  - No memory access; `hold_n` stays 1 and `drive_en` stays 0.
  - The strobe is tracked to DONE, then the block returns to IDLE.
- Boundary conditions:
  - `rd_n` and `wr_n` both low in ADDR: set `err`, make no access, go to DONE.
  - `ads_n` low in any non-IDLE state: abort the current cycle and restart as ADDR with the new address.
    - Any pending `mem_we` is not issued.
    - `drive_en` clears and `hold_n` returns to 1.
  - `rd_n`/`wr_n` low while IDLE (no preceding strobe): ignored.
  - A strobe released during WAIT: the access still completes, because the memory side is never left half-done, then the block returns to IDLE.
  - `rst_n` low mid-operation: all outputs return to reset values immediately; an in-flight `mem_we` or `mem_re` is dropped.

## Timing
- ADS sampled at edge E0: `mem_addr` is valid from E0.
- Read sampled at E1:
  - `mem_re` is high during cycle E1+W → E1+W+1.
  - `d_rsp`/`drive_en` are valid from E1+W+2.
  - `hold_n` is low over [E1, E1+W+2).
  - Latency from read sample to data is 2+W cycles.
- Write sampled at E1:
  - `mem_we` is high during cycle E1+W → E1+W+1.
  - `hold_n` is low over [E1, E1+W+1).
  - Latency is 1+W cycles.
- `mem_re` and `mem_we` are never high together and never last longer than one cycle.

## Configuration
- `SCMP_BUS_RSP_ROM_EN`:
  - Defined: the window is read-only. A hit write sets `err` and suppresses `mem_we`. `hold_n` still follows write timing.
  - Undefined: writes behave as described above.

## Test plan
- `BASE_ADDR` = 12'h400, `WIN_LOG2` = 8, W = 0. ADS with `addr` = 12'h412, then read with `mem_rdata` = 8'hA5 → `mem_addr` = 8'h12; `mem_re` pulses once; `d_rsp` = 8'hA5 two cycles after the rd sample; `drive_en` clears the edge after `rd_n` rises.
- W = 3, write 8'h3C to 12'h4FF → `hold_n` low for 4 cycles; single `mem_we` with `mem_wdata` = 8'h3C and `mem_addr` = 8'hFF.
- Miss: ADS 12'h500, then read → no `mem_re`, `hold_n` = 1, `drive_en` = 0 throughout.
- `rd_n` = `wr_n` = 0 after a hit ADS → `err` = 1, no memory pulse; a second ADS/read still completes normally.
- W = 5: re-assert `ads_n` two cycles into a write wait → no `mem_we`; new cycle decodes the new address. Separately, pulse `rst_n` mid-read → all outputs at reset values, state IDLE.
- With `SCMP_BUS_RSP_ROM_EN` defined: write 8'h77 to a hit address → `mem_we` never asserts, `err` = 1; a following read returns `mem_rdata`.
